// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state
// encoding, grant encoding and the default watchdog limit.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

   localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-requester round-robin pick. The grant output is combinational and
// follows the requests; last_grant only moves when the owner takes a grant.
import mem_port_arbiter_pkg::*;

module rr_arbiter2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req_if,
   input  logic req_dm,
   input  logic take,
   output logic grant,
   output logic any_req
);

   gnt_t last_grant;
   gnt_t pick;

   // Lone requester wins; on contention the one not served last wins.
   always_comb begin
      pick = GNT_IF;
      if (req_dm && !req_if)
         pick = GNT_DM;
      else if (req_dm && req_if)
         pick = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
   end

   assign grant   = pick;
   assign any_req = req_if | req_dm;

   // Remember the winner so the next contended pick goes the other way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= GNT_IF;
      else if (take)
         last_grant <= pick;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM stage requesters.
//
// Handshake: a requester raises req with its address (and we/wdata) and
// holds them until its ack pulses for one cycle; the arbiter samples
// requests only in IDLE, so a req still high during its own ack cycle is
// not re-granted. Toward memory, mem_en and the mem_* fields stay stable
// until mem_ack pulses (or the watchdog gives up); mem_ack outside an
// access is ignored.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              err_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o,
   output logic [CNT_W-1:0]  conflict_cnt_o
);

   // Watchdog counter is sized to hold TIMEOUT_CYC-1; it is unused when 0.
   localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   state_t            state;
   gnt_t              gnt_q;
   logic [WD_W-1:0]   wd_cnt;
   logic              pick;
   logic              any_req;
   logic              take;

   assign take = (state == ST_IDLE) && any_req;

   rr_arbiter2 u_rr (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .req_if  (if_req_i),
      .req_dm  (dm_req_i),
      .take    (take),
      .grant   (pick),
      .any_req (any_req)
   );

   // Access FSM: grant in IDLE, wait for memory or watchdog in BUSY,
   // pulse the owner's ack (and err on timeout) in RESP.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         gnt_q       <= GNT_IF;
         wd_cnt      <= '0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         dm_ack_o    <= 1'b0;
         err_o       <= 1'b0;
         if_data_o   <= '0;
         dm_rdata_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_q    <= gnt_t'(pick);
                  mem_en_o <= 1'b1;
                  wd_cnt   <= '0;
                  state    <= ST_BUSY;
                  if (pick == GNT_DM) begin
                     mem_we_o    <= dm_we_i;
                     mem_addr_o  <= dm_addr_i;
                     mem_wdata_o <= dm_wdata_i;
                  end else begin
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= if_addr_i;
                     mem_wdata_o <= '0;
                  end
               end
            end
            ST_BUSY: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (mem_ack_i) begin
                  mem_en_o <= 1'b0;
                  state    <= ST_RESP;
                  if (gnt_q == GNT_IF) begin
                     if_ack_o  <= 1'b1;
                     if_data_o <= mem_rdata_i;
                  end else begin
                     dm_ack_o <= 1'b1;
                     if (!mem_we_o)
                        dm_rdata_o <= mem_rdata_i;
                  end
               end else if (TIMEOUT_CYC != 0 && wd_cnt == WD_LAST) begin
                  mem_en_o <= 1'b0;
                  state    <= ST_RESP;
                  err_o    <= 1'b1;
                  if (gnt_q == GNT_IF)
                     if_ack_o <= 1'b1;
                  else
                     dm_ack_o <= 1'b1;
               end
            end
            ST_RESP: begin
               if_ack_o <= 1'b0;
               dm_ack_o <= 1'b0;
               err_o    <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Count cycles where both stages wait on each other; sticks at all-ones.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         conflict_cnt_o <= '0;
      else if (if_req_i && dm_req_i && !if_ack_o && !dm_ack_o &&
               conflict_cnt_o != {CNT_W{1'b1}})
         conflict_cnt_o <= conflict_cnt_o + 1'b1;
   end

   assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          if_req_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0;
   logic          if_ack_o;
   logic [DW-1:0] if_data_o;
   logic          dm_req_i = 1'b0;
   logic          dm_we_i = 1'b0;
   logic [AW-1:0] dm_addr_i = '0;
   logic [DW-1:0] dm_wdata_i = '0;
   logic          dm_ack_o;
   logic [DW-1:0] dm_rdata_o;
   logic          err_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          mem_ack_i = 1'b0;
   logic          stall_o;
   logic [CW-1:0] conflict_cnt_o;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .err_o(err_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .conflict_cnt_o(conflict_cnt_o)
   );

   int errors = 0;
   int checks = 0;
   bit rand_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   // mem_lat = N: ack is high in the N-th cycle of mem_en (0 = never acks).
   int            mem_lat = 1;
   int            en_age = 0;
   logic [DW-1:0] mem_rd_val = '0;

   always @(posedge clk_i) begin
      #1;
      if (mem_en_o) begin
         en_age++;
         if (rand_on && en_age == 1) mem_lat = $urandom_range(1, 20);
         mem_ack_i   = (mem_lat != 0) && (en_age == mem_lat);
         mem_rdata_i = rand_on ? DW'($urandom) : mem_rd_val;
      end else begin
         en_age      = 0;
         mem_ack_i   = rand_on && ($urandom_range(0, 7) == 0);
         mem_rdata_i = DW'($urandom);
      end
   end

   // ---------------- random requesters ----------------
   bit if_prev_ack = 1'b0;
   bit dm_prev_ack = 1'b0;

   always @(posedge clk_i) begin
      if (rand_on) begin
         #1;
         if (if_prev_ack || (if_req_i && $urandom_range(0, 40) == 0)) begin
            if_req_i = 1'b0;
         end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i  = 1'b1;
            if_addr_i = AW'($urandom);
         end
         if_prev_ack = if_ack_o;
         if (dm_prev_ack || (dm_req_i && $urandom_range(0, 40) == 0)) begin
            dm_req_i = 1'b0;
         end else if (!dm_req_i && $urandom_range(0, 2) == 0) begin
            dm_req_i   = 1'b1;
            dm_we_i    = 1'($urandom_range(0, 1));
            dm_addr_i  = AW'($urandom);
            dm_wdata_i = DW'($urandom);
         end
         dm_prev_ack = dm_ack_o;
      end
   end

   // ---------------- reference model ----------------
   // One outstanding access record plus the pending response; the owner
   // alternates under contention, first contended winner is data.
   bit            m_act = 0, m_dm = 0, m_we = 0, m_last_dm = 0;
   bit            m_if_ack = 0, m_dm_ack = 0, m_err = 0;
   int            m_age = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_if_data = '0, m_dm_rdata = '0;
   logic [CW-1:0] m_cnt = '0;

   function automatic bit pick_dm(input bit ifr, input bit dmr, input bit last_dm);
      if (ifr && dmr) return !last_dm;
      return dmr;
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_act <= 0; m_dm <= 0; m_we <= 0; m_last_dm <= 0;
         m_if_ack <= 0; m_dm_ack <= 0; m_err <= 0; m_age <= 0;
         m_addr <= '0; m_wdata <= '0; m_if_data <= '0; m_dm_rdata <= '0; m_cnt <= '0;
      end else begin
         if (if_req_i && dm_req_i && !m_if_ack && !m_dm_ack && m_cnt != {CW{1'b1}})
            m_cnt <= m_cnt + 1'b1;
         m_if_ack <= 0;
         m_dm_ack <= 0;
         m_err    <= 0;
         if (!(m_if_ack || m_dm_ack)) begin
            if (m_act) begin
               m_age <= m_age + 1;
               if (mem_ack_i || (TO != 0 && m_age + 1 == TO)) begin
                  m_act <= 0;
                  m_err <= !mem_ack_i;
                  if (m_dm) m_dm_ack <= 1; else m_if_ack <= 1;
                  if (mem_ack_i && !m_dm) m_if_data <= mem_rdata_i;
                  if (mem_ack_i && m_dm && !m_we) m_dm_rdata <= mem_rdata_i;
               end
            end else if (if_req_i || dm_req_i) begin
               m_act <= 1;
               m_age <= 0;
               if (pick_dm(if_req_i, dm_req_i, m_last_dm)) begin
                  m_dm <= 1; m_last_dm <= 1; m_we <= dm_we_i;
                  m_addr <= dm_addr_i; m_wdata <= dm_wdata_i;
               end else begin
                  m_dm <= 0; m_last_dm <= 0; m_we <= 0;
                  m_addr <= if_addr_i;
               end
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk_i) begin
      check("mem_en", 32'(mem_en_o), 32'(m_act));
      if (m_act) begin
         check("mem_we", 32'(mem_we_o), 32'(m_we));
         check("mem_addr", mem_addr_o, m_addr);
         if (m_we) check("mem_wdata", mem_wdata_o, m_wdata);
      end
      check("if_ack", 32'(if_ack_o), 32'(m_if_ack));
      check("dm_ack", 32'(dm_ack_o), 32'(m_dm_ack));
      check("err", 32'(err_o), 32'(m_err));
      check("if_data", if_data_o, m_if_data);
      check("dm_rdata", dm_rdata_o, m_dm_rdata);
      check("stall", 32'(stall_o), 32'((if_req_i & ~m_if_ack) | (dm_req_i & ~m_dm_ack)));
      check("conflict_cnt", 32'(conflict_cnt_o), 32'(m_cnt));
   end

   // ---------------- driver tasks ----------------
   task automatic clean();
      @(posedge clk_i); #1;
      if_req_i = 0; dm_req_i = 0; rst_i = 0; mem_lat = 1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1;
   endtask

   task automatic wait_hi(input int sel, input string name);
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk_i);
         case (sel)
            0: hit = mem_en_o;
            1: hit = if_ack_o;
            default: hit = dm_ack_o;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: timed out waiting", name);
      end
   endtask

   // One access from a lone requester; reports mem_en cycles and err at ack.
   task automatic serve(input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input int lat,
                        output int en_cycles, output bit err_at_ack);
      bit got = 0;
      en_cycles = 0;
      err_at_ack = 0;
      @(posedge clk_i); #1;
      mem_lat = lat;
      mem_rd_val = rd;
      if (is_if) begin
         if_req_i = 1; if_addr_i = addr;
      end else begin
         dm_req_i = 1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
      end
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk_i);
         if (mem_en_o) en_cycles++;
         got = is_if ? if_ack_o : dm_ack_o;
         if (got) begin
            err_at_ack = err_o;
            check("stall_at_ack", 32'(stall_o), 32'h0);
         end else begin
            check("stall_wait", 32'(stall_o), 32'h1);
         end
      end
      check("ack_seen", 32'(got), 32'h1);
      @(posedge clk_i); #1;
      if_req_i = 0;
      dm_req_i = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int  en_c, pulses, rises;
      bit  e, en_prev;
      logic [DW-1:0] held;

      // reset values
      #3;
      check("rst_mem_en", 32'(mem_en_o), 32'h0);
      check("rst_acks", 32'({if_ack_o, dm_ack_o, err_o}), 32'h0);
      check("rst_if_data", if_data_o, 32'h0);
      check("rst_dm_rdata", dm_rdata_o, 32'h0);
      check("rst_cnt", 32'(conflict_cnt_o), 32'h0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1;

      // 1: lone IF read, ack two cycles after mem_en rises
      serve(1, 0, 32'h100, 0, 32'h8C010004, 3, en_c, e);
      check("t1_if_data", if_data_o, 32'h8C010004);
      check("t1_en_cycles", 32'(en_c), 32'd3);
      pulses = 0;
      repeat (6) begin @(negedge clk_i); if (if_ack_o) pulses++; end
      check("t1_extra_acks", 32'(pulses), 32'd0);

      // 2: simultaneous requests after reset, data first
      clean();
      @(posedge clk_i); #1;
      mem_lat = 2;
      if_req_i = 1; if_addr_i = 32'h10;
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hCAFEF00D;
      wait_hi(0, "t2_first_en");
      check("t2_first_we", 32'(mem_we_o), 32'h1);
      check("t2_first_addr", mem_addr_o, 32'h200);
      check("t2_first_wdata", mem_wdata_o, 32'hCAFEF00D);
      wait_hi(2, "t2_dm_ack");
      check("t2_cnt_at_ack", 32'(conflict_cnt_o), 32'd3);
      @(posedge clk_i); #1 dm_req_i = 0;
      wait_hi(0, "t2_second_en");
      check("t2_second_addr", mem_addr_o, 32'h10);
      check("t2_second_we", 32'(mem_we_o), 32'h0);
      wait_hi(1, "t2_if_ack");
      @(posedge clk_i); #1 if_req_i = 0;

      // 3: a write leaves the read register alone
      clean();
      serve(0, 0, 32'h40, 0, 32'h12345678, 1, en_c, e);
      check("t3_read", dm_rdata_o, 32'h12345678);
      serve(0, 1, 32'h44, 32'h0BADF00D, 32'hDEADBEEF, 1, en_c, e);
      check("t3_after_write", dm_rdata_o, 32'h12345678);

      // 4: watchdog abort, then a normal access
      held = dm_rdata_o;
      serve(0, 0, 32'h80, 0, 32'h55555555, 0, en_c, e);
      check("t4_en_cycles", 32'(en_c), 32'd16);
      check("t4_err_with_ack", 32'(e), 32'h1);
      check("t4_rdata_kept", dm_rdata_o, held);
      serve(0, 0, 32'h84, 0, 32'hA5A5A5A5, 2, en_c, e);
      check("t4_next_err", 32'(e), 32'h0);
      check("t4_next_rdata", dm_rdata_o, 32'hA5A5A5A5);

      // 5: reset in the middle of an access
      clean();
      @(posedge clk_i); #1;
      mem_lat = 0;
      if_req_i = 1; if_addr_i = 32'h300;
      dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h400;
      wait_hi(0, "t5_en");
      @(negedge clk_i);
      #2 rst_i = 0;
      #1;
      check("t5_en_dropped", 32'(mem_en_o), 32'h0);
      check("t5_acks_zero", 32'({if_ack_o, dm_ack_o}), 32'h0);
      check("t5_cnt_zero", 32'(conflict_cnt_o), 32'h0);
      @(posedge clk_i); #1 rst_i = 1;
      wait_hi(0, "t5_regrant");
      check("t5_data_first", mem_addr_o, 32'h400);

      // 6: data request dropped mid-access still completes once
      clean();
      @(posedge clk_i); #1;
      mem_lat = 5; mem_rd_val = 32'h0F0F1234;
      dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h500;
      wait_hi(0, "t6_en");
      @(posedge clk_i); #1 dm_req_i = 0;
      pulses = 0; rises = 0; en_prev = 1;
      repeat (20) begin
         @(negedge clk_i);
         if (dm_ack_o) pulses++;
         if (mem_en_o && !en_prev) rises++;
         en_prev = mem_en_o;
      end
      check("t6_ack_pulses", 32'(pulses), 32'd1);
      check("t6_no_regrant", 32'(rises), 32'd0);
      check("t6_rdata", dm_rdata_o, 32'h0F0F1234);

      // random phase
      clean();
      @(negedge clk_i) rand_on = 1;
      repeat (3000) @(posedge clk_i);
      @(negedge clk_i) rand_on = 0;
      @(posedge clk_i); #1;
      if_req_i = 0; dm_req_i = 0; mem_ack_i = 0;
      repeat (25) @(posedge clk_i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
